// File: rtl/prog_fetch_seq_pkg.sv
// Shared definitions for the program fetch sequencer:
// state encoding, opcode constants and instruction field positions.
package prog_fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_LATCH  = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_COMMIT = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [7:0] OP_HALT = 8'hFF;
    localparam logic [7:0] OP_IMMD = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h10;
    localparam logic [7:0] OP_COPY = 8'h20;
    localparam logic [7:0] OP_NEP  = 8'h27;

    localparam int OP_HI = 31;
    localparam int OP_LO = 24;
    localparam int A1_HI = 23;
    localparam int A1_LO = 16;
    localparam int A2_HI = 15;
    localparam int A2_LO = 8;
    localparam int A3_HI = 7;
    localparam int A3_LO = 0;

endpackage

// File: rtl/prog_fetch_seq_tick_gen.sv
// Free-running divider producing a one-cycle step tick
// every TICK_DIV clocks; clr holds it at zero.
module tick_gen #(
    parameter int TICK_DIV = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(TICK_DIV - 1));
    assign tick   = w_last & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/prog_fetch_seq.sv
// Program memory reader: fetches, decodes and issues instruction
// words at the step rate and commits the PC from the processor result.
module prog_fetch_seq
    import prog_fetch_seq_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          LAST_ADDR = 127,
    parameter int          TICK_DIV  = 2_000_000,
    parameter logic [7:0]  HALT_OP   = OP_HALT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step_mode,
    input  logic              step_req,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [7:0]        oper,
    output logic [7:0]        addr1,
    output logic [7:0]        addr2,
    output logic [7:0]        addr3,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [ADDR_W:0] LAST_EXT = (ADDR_W + 1)'(LAST_ADDR);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [31:0]         r_instr;
    logic [31:0]         w_instr_nxt;
    logic                r_step_d;
    logic                w_step_rise;
    logic                w_tick;
    logic                w_go;
    logic                w_rd_en;
    logic                w_valid;
    logic [ADDR_W:0]     w_pc_ext;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (~run),
        .tick (w_tick)
    );

    assign w_step_rise = step_req & ~r_step_d;
    assign w_go        = step_mode ? w_step_rise : w_tick;

    // Carry bit catches the pc+1 wrap so it halts like any out-of-range pc
    assign w_pc_ext = jump ? {1'b0, jump_target}
                           : ({1'b0, r_pc} + (ADDR_W + 1)'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_rd_en     = 1'b0;
        w_valid     = 1'b0;
        if (!run) begin
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = '0;
            w_instr_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_go) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = ST_LATCH;
                end
                ST_LATCH: begin
                    if (mem_rd_data[OP_HI:OP_LO] == HALT_OP) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_instr_nxt = mem_rd_data;
                        w_state_nxt = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    w_valid     = 1'b1;
                    w_state_nxt = ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (w_pc_ext > LAST_EXT) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt    = w_pc_ext[ADDR_W-1:0];
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_HALT: begin
                    w_state_nxt = ST_HALT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= '0;
            r_instr  <= '0;
            r_step_d <= 1'b0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_step_d <= step_req;
        end
    end

    assign mem_rd_en   = w_rd_en;
    assign mem_addr    = r_pc;
    assign instr_valid = w_valid;
    assign pc          = r_pc;
    assign halted      = (r_state == ST_HALT);
    assign oper        = r_instr[OP_HI:OP_LO];
    assign addr1       = r_instr[A1_HI:A1_LO];
    assign addr2       = r_instr[A2_HI:A2_LO];
    assign addr3       = r_instr[A3_HI:A3_LO];

endmodule

// File: tb/tb_prog_fetch_seq.sv
// Scoreboard bench for prog_fetch_seq with a small tick divider,
// a short program space and a one-cycle-latency memory model.
module tb_prog_fetch_seq;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          step_mode = 1'b0;
    logic          step_req = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_q = '0;
    logic          jump = 1'b0;
    logic [AW-1:0] jump_target = '0;
    logic [7:0]    oper, addr1, addr2, addr3;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          halted;

    logic [31:0]   mem [256];
    logic [31:0]   sb_q [$];
    int            n_tot = 0;
    int            n_bad = 0;
    int            n_valid = 0;

    prog_fetch_seq #(
        .ADDR_W    (AW),
        .LAST_ADDR (7),
        .TICK_DIV  (4),
        .HALT_OP   (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_q),
        .jump        (jump),
        .jump_target (jump_target),
        .oper        (oper),
        .addr1       (addr1),
        .addr2       (addr2),
        .addr3       (addr3),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_q <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (instr_valid) begin
            n_valid++;
            if (sb_q.size() == 0) begin
                check("extra_valid", 32'(sb_q.size()), 32'd1);
            end else begin
                check("instr", {oper, addr1, addr2, addr3}, sb_q.pop_front());
            end
        end
    end

    task automatic wait_valid(input int target, input string tag);
        for (int k = 0; k < 300 && n_valid < target; k++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 32'(n_valid >= target), 32'd1);
    endtask

    task automatic wait_halt(input string tag);
        for (int k = 0; k < 300 && !halted; k++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    task automatic wait_rd(input string tag);
        for (int k = 0; k < 300 && !mem_rd_en; k++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 32'(mem_rd_en), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 32'h00_05_00_00;
        mem[1] = 32'h00_09_00_06;
        mem[2] = 32'h10_02_03_04;
        mem[3] = 32'h27_02_06_00;
        mem[4] = 32'hFF_11_22_33;
        mem[7] = 32'h30_01_02_03;

        repeat (3) @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ops", {oper, addr1, addr2, addr3}, 32'd0);
        check("rst_flags", {29'd0, instr_valid, halted, mem_rd_en}, 32'd0);
        rst = 1'b0;

        // sequential issue of words 0..2
        sb_q.push_back(mem[0]);
        sb_q.push_back(mem[1]);
        sb_q.push_back(mem[2]);
        run = 1'b1;
        wait_valid(3, "seq_tmo");
        @(posedge clk);
        @(posedge clk);
        #1;
        check("seq_pc", 32'(pc), 32'd3);

        // taken jump back to 1
        sb_q.push_back(mem[3]);
        wait_valid(4, "jmp_tmo");
        jump = 1'b1;
        jump_target = 8'd1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("jmp_pc", 32'(pc), 32'd1);
        check("jmp_addr", 32'(mem_addr), 32'd1);
        jump = 1'b0;

        // runs 1..3 then hits the halt opcode at 4
        sb_q.push_back(mem[1]);
        sb_q.push_back(mem[2]);
        sb_q.push_back(mem[3]);
        wait_halt("halt_tmo");
        repeat (5) @(negedge clk);
        check("halt_pc", 32'(pc), 32'd4);
        check("halt_ops", {oper, addr1, addr2, addr3}, 32'h27_02_06_00);
        check("halt_cnt", 32'(n_valid), 32'd7);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("idle_pc", 32'(pc), 32'd0);
        check("idle_halt", 32'(halted), 32'd0);

        // reset asserted while issuing
        sb_q.push_back(mem[0]);
        run = 1'b1;
        wait_valid(8, "rstmid_tmo");
        rst = 1'b1;
        #1;
        check("rstmid_valid", 32'(instr_valid), 32'd0);
        check("rstmid_ops", {oper, addr1, addr2, addr3}, 32'd0);
        check("rstmid_st", {pc, halted, mem_rd_en}, 32'd0);
        @(negedge clk);
        run = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // run dropped in LATCH
        run = 1'b1;
        wait_rd("drop_tmo");
        @(posedge clk);
        #1;
        run = 1'b0;
        @(posedge clk);
        #1;
        check("drop_pc", 32'(pc), 32'd0);
        repeat (10) @(negedge clk);
        check("drop_cnt", 32'(n_valid), 32'd8);

        // rerun starts from address 0
        sb_q.push_back(mem[0]);
        run = 1'b1;
        wait_rd("rerun_tmo");
        check("rerun_addr", 32'(mem_addr), 32'd0);
        wait_valid(9, "rerun_v_tmo");
        @(posedge clk);
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (2) @(negedge clk);

        // step mode: one instruction per rising edge
        step_mode = 1'b1;
        sb_q.push_back(mem[0]);
        run = 1'b1;
        repeat (3) @(negedge clk);
        step_req = 1'b1;
        repeat (10) @(negedge clk);
        step_req = 1'b0;
        repeat (10) @(negedge clk);
        check("step_cnt", 32'(n_valid), 32'd10);
        check("step_pc", 32'(pc), 32'd1);

        sb_q.push_back(mem[1]);
        step_req = 1'b1;
        wait_valid(11, "step2_tmo");
        jump = 1'b1;
        jump_target = 8'd7;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("step2_pc", 32'(pc), 32'd7);
        jump = 1'b0;
        step_req = 1'b0;
        repeat (2) @(negedge clk);

        // commit past the last address halts
        sb_q.push_back(mem[7]);
        step_req = 1'b1;
        wait_valid(12, "step3_tmo");
        repeat (3) @(posedge clk);
        #1;
        check("last_halt", 32'(halted), 32'd1);
        step_req = 1'b0;
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("end_cnt", 32'(n_valid), 32'd12);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
